rib_timer: RTL and testbench



---
 rtl/rib_timer_pkg.sv | 35 +++
 rtl/rib_timer_prescaler.sv | 34 +++
 rtl/rib_timer.sv | 135 +++++++++++++
 tb/tb_rib_timer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_timer_pkg.sv
// rib_timer_pkg: shared definitions for the RIB timer peripheral.
//   - bus widths for the data and address buses
//   - register offsets, selected by word address bits [3:2]
//   - CTRL bit positions and a packed view of the CTRL register
package rib_timer_pkg;

  localparam int MEM_BUS_W      = 32;
  localparam int MEM_ADDR_BUS_W = 32;

  // Word offsets within the 16-byte register window
  localparam logic [1:0] TIMER_CTRL  = 2'd0;  // 0x0
  localparam logic [1:0] TIMER_COUNT = 2'd1;  // 0x4
  localparam logic [1:0] TIMER_LIMIT = 2'd2;  // 0x8
  localparam logic [1:0] TIMER_PRESC = 2'd3;  // 0xC

  // CTRL bit indices
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;
  localparam int CTRL_AUTO = 3;

  // Member order matches the bit indices above (auto_rl is bit 3, en is bit 0)
  typedef struct packed {
    logic auto_rl;
    logic pend;
    logic ie;
    logic en;
  } ctrl_t;

  // CTRL as seen on the bus: unused upper bits read as zero
  function automatic logic [MEM_BUS_W-1:0] ctrl_to_word(input ctrl_t c);
    return {{(MEM_BUS_W-4){1'b0}}, c};
  endfunction

endpackage

// File: rtl/rib_timer_prescaler.sv
// timer_prescaler: divides clk into timer ticks.
//   clk     : system clock
//   rst     : asynchronous reset, active-low
//   en_i    : prescaler runs while high, held at zero while low
//   presc_i : divide value; a tick fires when the internal count equals it
//   clr_i   : restart the internal count (used on a PRESC write)
//   tick_o  : one-cycle tick, combinational from the internal count
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] presc_i,
  input  logic                  clr_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pcnt_reg;

  // A divide value of N gives one tick every N+1 cycles
  assign tick_o = en_i && (pcnt_reg == presc_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_reg <= '0;
    end else if (clr_i || !en_i || tick_o) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rib_timer.sv
// rib_timer: memory-mapped 32-bit timer on the RIB responder side.
//   clk    : system clock
//   rst    : asynchronous reset, active-low
//   req_i  : bus access request, one cycle per access
//   we_i   : 1 = write, 0 = read (qualified by req_i)
//   addr_i : byte address, only [3:2] decoded
//   data_i : write data
//   data_o : read data, combinational, zero when not reading
//   int_o  : level interrupt, registered PEND & IE
// Register map: 0x0 CTRL {AUTO,PEND,IE,EN}, 0x4 COUNT, 0x8 LIMIT, 0xC PRESC.
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] LIMIT_RST  = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [MEM_ADDR_BUS_W-1:0] addr_i,
  input  logic [MEM_BUS_W-1:0]      data_i,
  output logic [MEM_BUS_W-1:0]      data_o,
  output logic                      int_o
);

  ctrl_t                 ctrl_reg,  ctrl_next;
  logic [MEM_BUS_W-1:0]  count_reg, count_next;
  logic [MEM_BUS_W-1:0]  limit_reg, limit_next;
  logic [PRESCALE_W-1:0] presc_reg, presc_next;
  logic                  int_reg;

  logic       wr_en;
  logic [1:0] reg_sel;
  logic       presc_wr;
  logic       tick;
  logic       match;
  logic [MEM_BUS_W-1:0] rd_word;

  // Upper address bits are decoded by the fabric
  logic unused_addr;
  assign unused_addr = ^{addr_i[MEM_ADDR_BUS_W-1:4], addr_i[1:0]};

  assign wr_en    = req_i && we_i;
  assign reg_sel  = addr_i[3:2];
  assign presc_wr = wr_en && (reg_sel == TIMER_PRESC);

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ctrl_reg.en),
    .presc_i(presc_reg),
    .clr_i  (presc_wr),
    .tick_o (tick)
  );

  // Match is judged on the pre-write COUNT, so a same-cycle COUNT write
  // cannot hide a match.
  assign match = tick && (count_reg == limit_reg);

  // Ordering inside this block encodes collision priority: timer update
  // first, then bus writes override it, then a match sets PEND last so
  // set beats write-1-to-clear.
  always_comb begin
    ctrl_next  = ctrl_reg;
    count_next = count_reg;
    limit_next = limit_reg;
    presc_next = presc_reg;

    if (tick) begin
      if (match) begin
        count_next = '0;
        if (!ctrl_reg.auto_rl) begin
          ctrl_next.en = 1'b0;
        end
      end else begin
        count_next = count_reg + 32'd1;
      end
    end

    if (wr_en) begin
      case (reg_sel)
        TIMER_CTRL: begin
          ctrl_next.en      = data_i[CTRL_EN];
          ctrl_next.ie      = data_i[CTRL_IE];
          ctrl_next.auto_rl = data_i[CTRL_AUTO];
          if (data_i[CTRL_PEND]) begin
            ctrl_next.pend = 1'b0;
          end
        end
        TIMER_COUNT: count_next = data_i;
        TIMER_LIMIT: limit_next = data_i;
        TIMER_PRESC: presc_next = data_i[PRESCALE_W-1:0];
        default: ;
      endcase
    end

    if (match) begin
      ctrl_next.pend = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_reg  <= '0;
      count_reg <= '0;
      limit_reg <= LIMIT_RST;
      presc_reg <= '0;
      int_reg   <= 1'b0;
    end else begin
      ctrl_reg  <= ctrl_next;
      count_reg <= count_next;
      limit_reg <= limit_next;
      presc_reg <= presc_next;
      int_reg   <= ctrl_reg.pend && ctrl_reg.ie;
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      TIMER_CTRL:  rd_word = ctrl_to_word(ctrl_reg);
      TIMER_COUNT: rd_word = count_reg;
      TIMER_LIMIT: rd_word = limit_reg;
      TIMER_PRESC: rd_word = {{(MEM_BUS_W-PRESCALE_W){1'b0}}, presc_reg};
      default:     rd_word = '0;
    endcase
  end

  assign data_o = (req_i && !we_i) ? rd_word : '0;
  assign int_o  = int_reg;

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: self-checking bench for rib_timer.
// Register R/W vectors come from a table; timer sequences are hand-written.
// Expected read data goes through a small scoreboard queue.
module tb_rib_timer;

  localparam logic [31:0] A_CTRL  = 32'h0;
  localparam logic [31:0] A_COUNT = 32'h4;
  localparam logic [31:0] A_LIMIT = 32'h8;
  localparam logic [31:0] A_PRESC = 32'hC;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  rib_timer #(
    .PRESCALE_W(16),
    .LIMIT_RST (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .we_i  (we),
    .addr_i(addr),
    .data_i(wdata),
    .data_o(rdata),
    .int_o (irq)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    $display("[TB] wr addr=0x%08h data=0x%08h", a, d);
  endtask

  // Read is combinational: drive, wait 1ns, compare; never crosses an edge
  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] e;
    string       n;
    exp_q.push_back(exp);
    name_q.push_back(name);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    $display("[TB] rd %s addr=0x%08h data=0x%08h exp=0x%08h", n, a, rdata, e);
    check(n, rdata, e);
    req = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset with random bus traffic, then check reset contents
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      req   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wdata = $urandom;
    end
    @(negedge clk);
    req = 1'b0; we = 1'b0; rst = 1'b1;
    #1;
    check("reset int_o", {31'b0, irq}, 32'h0);
    bus_read(A_CTRL,  32'h0,         "reset CTRL");
    bus_read(A_COUNT, 32'h0,         "reset COUNT");
    bus_read(A_LIMIT, 32'hFFFF_FFFF, "reset LIMIT");
    bus_read(A_PRESC, 32'h0,         "reset PRESC");

    // Register read/write table
    vecs[0] = '{we: 1'b1, addr: A_LIMIT, data: 32'h1234_5678, exp: 32'h0};
    vecs[1] = '{we: 1'b0, addr: A_LIMIT, data: 32'h0,         exp: 32'h1234_5678};
    vecs[2] = '{we: 1'b1, addr: A_COUNT, data: 32'hDEAD_0001, exp: 32'h0};
    vecs[3] = '{we: 1'b0, addr: A_COUNT, data: 32'h0,         exp: 32'hDEAD_0001};
    vecs[4] = '{we: 1'b1, addr: A_PRESC, data: 32'hFFFF_ABCD, exp: 32'h0};
    vecs[5] = '{we: 1'b0, addr: A_PRESC, data: 32'h0,         exp: 32'h0000_ABCD};
    vecs[6] = '{we: 1'b1, addr: A_CTRL,  data: 32'hFFFF_FFF0, exp: 32'h0};
    vecs[7] = '{we: 1'b0, addr: A_CTRL,  data: 32'h0,         exp: 32'h0};
    vecs[8] = '{we: 1'b0, addr: 32'h1C,  data: 32'h0,         exp: 32'h0000_ABCD};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].data);
      else            bus_read(vecs[i].addr, vecs[i].exp, $sformatf("table vec %0d", i));
    end
    addr = A_LIMIT;
    #1;
    check("idle data_o", rdata, 32'h0);

    // Auto-reload, LIMIT=3, PRESC=0
    do_reset();
    bus_write(A_LIMIT, 32'd3);
    bus_write(A_CTRL, 32'hB);
    step(1); bus_read(A_COUNT, 32'd1, "auto count 1");
    step(1); bus_read(A_COUNT, 32'd2, "auto count 2");
    step(1); bus_read(A_COUNT, 32'd3, "auto count 3");
    step(1); bus_read(A_COUNT, 32'd0, "auto count wrap");
    bus_read(A_CTRL, 32'hF, "auto pend set");
    check("auto int_o before", {31'b0, irq}, 32'h0);
    step(1); bus_read(A_COUNT, 32'd1, "auto count 1 again");
    check("auto int_o high", {31'b0, irq}, 32'h1);
    bus_write(A_CTRL, 32'hF);
    check("auto int_o still high", {31'b0, irq}, 32'h1);
    bus_read(A_CTRL, 32'hB, "auto pend cleared");
    step(1);
    check("auto int_o dropped", {31'b0, irq}, 32'h0);

    // Prescale and one-shot: PRESC=4, LIMIT=2, CTRL=IE|EN
    do_reset();
    bus_write(A_PRESC, 32'd4);
    bus_write(A_LIMIT, 32'd2);
    bus_write(A_CTRL, 32'h3);
    for (int k = 1; k <= 15; k++) begin
      logic [31:0] e;
      e = (k == 15) ? 32'd0 : 32'(k / 5);
      step(1);
      bus_read(A_COUNT, e, $sformatf("oneshot count cyc %0d", k));
    end
    bus_read(A_CTRL, 32'h6, "oneshot ctrl after match");
    for (int k = 0; k < 50; k++) begin
      step(1);
      bus_read(A_COUNT, 32'd0, "oneshot count held");
      if (k == 0) check("oneshot int_o", {31'b0, irq}, 32'h1);
    end

    // Collision: W1C on the match edge, set wins
    do_reset();
    bus_write(A_LIMIT, 32'd3);
    bus_write(A_CTRL, 32'hB);
    step(3);
    bus_write(A_CTRL, 32'hF);
    bus_read(A_CTRL,  32'hF, "w1c vs match pend");
    bus_read(A_COUNT, 32'd0, "w1c vs match count");

    // Collision: COUNT write on a matching tick
    do_reset();
    bus_write(A_LIMIT, 32'd2);
    bus_write(A_CTRL, 32'h9);
    step(2);
    bus_write(A_COUNT, 32'h100);
    bus_read(A_COUNT, 32'h100, "count write vs tick");
    bus_read(A_CTRL,  32'hD,   "count write keeps match pend");
    step(1); bus_read(A_COUNT, 32'h101, "count after write");
    step(1); bus_read(A_COUNT, 32'h102, "limit below count");

    // Collision: EN write on a one-shot match
    do_reset();
    bus_write(A_LIMIT, 32'd1);
    bus_write(A_CTRL, 32'h1);
    step(1);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL,  32'h5, "en write vs oneshot");
    bus_read(A_COUNT, 32'd0, "en write vs oneshot count");
    step(1); bus_read(A_COUNT, 32'd1, "en write keeps running");

    // Wrap through 0xFFFF_FFFF without PEND
    do_reset();
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_write(A_LIMIT, 32'd5);
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 7; i++) begin
      logic [31:0] e;
      e = 32'hFFFF_FFFF + 32'(i);
      step(1);
      bus_read(A_COUNT, e, $sformatf("wrap count %0d", i));
      bus_read(A_CTRL, 32'h1, $sformatf("wrap no pend %0d", i));
    end
    step(1);
    bus_read(A_COUNT, 32'd0, "wrap match count");
    bus_read(A_CTRL,  32'h4, "wrap match pend");

    // Async reset between edges while running with int_o high
    do_reset();
    bus_write(A_LIMIT, 32'd2);
    bus_write(A_CTRL, 32'hB);
    step(4);
    check("async pre int_o", {31'b0, irq}, 32'h1);
    bus_read(A_COUNT, 32'd1, "async pre count");
    rst = 1'b0;
    #1;
    check("async int_o cleared", {31'b0, irq}, 32'h0);
    bus_read(A_CTRL,  32'h0,         "async CTRL");
    bus_read(A_COUNT, 32'h0,         "async COUNT");
    bus_read(A_LIMIT, 32'hFFFF_FFFF, "async LIMIT");
    bus_read(A_PRESC, 32'h0,         "async PRESC");
    @(negedge clk);
    rst = 1'b1;
    step(2);
    bus_read(A_COUNT, 32'h0, "post reset idle count");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
